rtc_bus_transaction_ctrl: RTL and testbench

- Downstream of the RTC sequencing FSM. Turns each single-register request (address, write data, read/write, enable) into the timed address/data-multiplexed bus cycle for the RTC chip.
- Returns a one-cycle done pulse, which is what advances the FSM's step counter.
- On reads, captures the returned byte with its address for the display/register bank.

---
 rtl/rtc_bus_pkg.sv | 48 ++++
 rtl/rtc_bus_phase_timer.sv | 38 +++
 rtl/rtc_bus_transaction_ctrl.sv | 167 ++++++++++++++++
 tb/tb_rtc_bus_transaction_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus transaction controller and its sequencer.
// Contents:
//   bus_state_e     - bus cycle state encoding
//   T_FASE_DEF      - default clock cycles per bus phase (legal 1..15)
//   CMD_BASE_DEF    - addresses at or above this are command cycles (address phase only)
//   ADDR_*          - register and command addresses used by the sequencer
//   phase_reload()  - phase timer reload value for a given phase length
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_SETUP  = 3'd1,
        A_STROBE = 3'd2,
        A_HOLD   = 3'd3,
        D_SETUP  = 3'd4,
        D_STROBE = 3'd5,
        D_HOLD   = 3'd6,
        DONE     = 3'd7
    } bus_state_e;

    localparam int unsigned T_FASE_DEF   = 4;
    localparam logic [7:0]  CMD_BASE_DEF = 8'hF0;

    // Command cycles
    localparam logic [7:0] ADDR_CMD_F0 = 8'hF0;
    localparam logic [7:0] ADDR_CMD_F1 = 8'hF1;
    localparam logic [7:0] ADDR_CMD_F2 = 8'hF2;

    // Clock / calendar registers
    localparam logic [7:0] ADDR_SEG     = 8'h21;
    localparam logic [7:0] ADDR_MIN     = 8'h22;
    localparam logic [7:0] ADDR_HORA    = 8'h23;
    localparam logic [7:0] ADDR_DIA     = 8'h24;
    localparam logic [7:0] ADDR_MES     = 8'h25;
    localparam logic [7:0] ADDR_ANIO    = 8'h26;
    localparam logic [7:0] ADDR_DIA_SEM = 8'h27;

    // Timer registers
    localparam logic [7:0] ADDR_T_SEG  = 8'h41;
    localparam logic [7:0] ADDR_T_MIN  = 8'h42;
    localparam logic [7:0] ADDR_T_HORA = 8'h43;

    // The timer counts T-1 down to 0, so a phase occupies exactly T cycles.
    function automatic logic [3:0] phase_reload(input int unsigned t_fase);
        return 4'(t_fase - 1);
    endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Phase timer for the RTC bus controller: 4-bit down-counter.
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   load_i     - reload the counter with load_val_i (asserted on state entry)
//   load_val_i - reload value (phase length minus one)
//   tc_o       - terminal count: counter is at zero (last cycle of the phase)
module rtc_bus_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic       tc_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == 4'd0);

endmodule

// File: rtl/rtc_bus_transaction_ctrl.sv
// RTC bus transaction controller: converts one register request from the
// sequencer into a timed address/data multiplexed bus cycle.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   in_en_funcion_rtc       - request (sampled only in IDLE)
//   in_funcion_w_r          - 1 = write, 0 = read
//   in_flag_inicio          - write data source select (1 = init data, 0 = user data)
//   in_addr_ram_rtc         - register / command address
//   in_dato_inicio          - init-sequence write data
//   in_dato_usuario         - user write data
//   in_bus                  - AD bus read value
//   out_bus, out_bus_oe     - AD bus drive value and enable
//   out_cs_n, out_rd_n, out_wr_n, out_ad - bus control (all registered)
//   out_flag_done           - one-cycle completion pulse
//   out_dato_leido, out_addr_leido - last read byte and its address
//   out_dato_valido         - one-cycle strobe with done on register reads
// Handshake: a request is accepted on any edge where the controller is IDLE and
// in_en_funcion_rtc = 1; the request inputs are then ignored until done has
// pulsed and the controller is back in IDLE.
module rtc_bus_transaction_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_FASE   = T_FASE_DEF,
    parameter logic [7:0]  CMD_BASE = CMD_BASE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en_funcion_rtc,
    input  logic       in_funcion_w_r,
    input  logic       in_flag_inicio,
    input  logic [7:0] in_addr_ram_rtc,
    input  logic [7:0] in_dato_inicio,
    input  logic [7:0] in_dato_usuario,
    input  logic [7:0] in_bus,
    output logic [7:0] out_bus,
    output logic       out_bus_oe,
    output logic       out_cs_n,
    output logic       out_rd_n,
    output logic       out_wr_n,
    output logic       out_ad,
    output logic       out_flag_done,
    output logic [7:0] out_dato_leido,
    output logic [7:0] out_addr_leido,
    output logic       out_dato_valido
);

    localparam logic [3:0] PHASE_RELOAD = phase_reload(T_FASE);

    bus_state_e state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic       wr_q, wr_d;
    logic [7:0] rd_q;
    logic       tc;
    logic       accept;
    logic       is_cmd;

    assign accept = (state_q == IDLE) && in_en_funcion_rtc;
    assign is_cmd = (addr_q >= CMD_BASE);

    // Request latch values; outputs are registered from these so the address
    // is already on the bus in the first A_SETUP cycle.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        wr_d   = wr_q;
        if (accept) begin
            addr_d = in_addr_ram_rtc;
            data_d = in_flag_inicio ? in_dato_inicio : in_dato_usuario;
            wr_d   = in_funcion_w_r;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (in_en_funcion_rtc) state_d = A_SETUP;
            A_SETUP:  if (tc) state_d = A_STROBE;
            A_STROBE: if (tc) state_d = A_HOLD;
            A_HOLD:   if (tc) state_d = is_cmd ? DONE : D_SETUP;
            D_SETUP:  if (tc) state_d = D_STROBE;
            D_STROBE: if (tc) state_d = D_HOLD;
            D_HOLD:   if (tc) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    rtc_bus_phase_timer u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (state_d != state_q),
        .load_val_i(PHASE_RELOAD),
        .tc_o      (tc)
    );

    // Outputs are decoded from the next state and registered, so every strobe
    // changes only on a phase boundary and is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= 8'h00;
            data_q          <= 8'h00;
            wr_q            <= 1'b0;
            rd_q            <= 8'h00;
            out_bus         <= 8'h00;
            out_bus_oe      <= 1'b0;
            out_cs_n        <= 1'b1;
            out_rd_n        <= 1'b1;
            out_wr_n        <= 1'b1;
            out_ad          <= 1'b1;
            out_flag_done   <= 1'b0;
            out_dato_valido <= 1'b0;
            out_dato_leido  <= 8'h00;
            out_addr_leido  <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            // Read data is taken at the end of the last read-strobe cycle.
            if (state_q == D_STROBE && tc) begin
                rd_q <= in_bus;
            end

            out_bus         <= 8'h00;
            out_bus_oe      <= 1'b0;
            out_cs_n        <= 1'b1;
            out_rd_n        <= 1'b1;
            out_wr_n        <= 1'b1;
            out_ad          <= 1'b1;
            out_flag_done   <= 1'b0;
            out_dato_valido <= 1'b0;

            unique case (state_d)
                A_SETUP, A_STROBE, A_HOLD: begin
                    out_bus    <= addr_d;
                    out_bus_oe <= 1'b1;
                    out_cs_n   <= 1'b0;
                    out_wr_n   <= (state_d != A_STROBE);
                end
                D_SETUP, D_STROBE, D_HOLD: begin
                    out_ad   <= 1'b0;
                    out_cs_n <= 1'b0;
                    if (wr_d) begin
                        out_bus    <= data_d;
                        out_bus_oe <= 1'b1;
                        out_wr_n   <= (state_d != D_STROBE);
                    end else begin
                        out_rd_n   <= (state_d != D_STROBE);
                    end
                end
                DONE: begin
                    out_flag_done <= 1'b1;
                    if (!wr_q && !is_cmd) begin
                        out_dato_valido <= 1'b1;
                        out_dato_leido  <= rd_q;
                        out_addr_leido  <= addr_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_transaction_ctrl.sv
// Bench for rtc_bus_transaction_ctrl. The expected waveform of every cycle is
// derived from the cycle's offset after the accepting edge: offset k falls in
// bus phase (k-1)/T_FASE, done lands at offset 6*T_FASE+1 (3*T_FASE+1 for
// commands). Read bytes expected at done are kept in exp_q.
module tb_rtc_bus_transaction_ctrl;
    import rtc_bus_pkg::*;

    localparam int TF = 4;
    localparam logic [7:0] CMDB = 8'hF0;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_en_funcion_rtc;
    logic       in_funcion_w_r;
    logic       in_flag_inicio;
    logic [7:0] in_addr_ram_rtc;
    logic [7:0] in_dato_inicio;
    logic [7:0] in_dato_usuario;
    logic [7:0] in_bus;
    logic [7:0] out_bus;
    logic       out_bus_oe;
    logic       out_cs_n;
    logic       out_rd_n;
    logic       out_wr_n;
    logic       out_ad;
    logic       out_flag_done;
    logic [7:0] out_dato_leido;
    logic [7:0] out_addr_leido;
    logic       out_dato_valido;

    rtc_bus_transaction_ctrl #(.T_FASE(TF), .CMD_BASE(CMDB)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_en_funcion_rtc(in_en_funcion_rtc),
        .in_funcion_w_r   (in_funcion_w_r),
        .in_flag_inicio   (in_flag_inicio),
        .in_addr_ram_rtc  (in_addr_ram_rtc),
        .in_dato_inicio   (in_dato_inicio),
        .in_dato_usuario  (in_dato_usuario),
        .in_bus           (in_bus),
        .out_bus          (out_bus),
        .out_bus_oe       (out_bus_oe),
        .out_cs_n         (out_cs_n),
        .out_rd_n         (out_rd_n),
        .out_wr_n         (out_wr_n),
        .out_ad           (out_ad),
        .out_flag_done    (out_flag_done),
        .out_dato_leido   (out_dato_leido),
        .out_addr_leido   (out_addr_leido),
        .out_dato_valido  (out_dato_valido)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_leido = 8'h00;
    logic [7:0] exp_addr_leido = 8'h00;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: outputs at offset k after the accepting edge (k = 0 means idle).
    task automatic check_cycle(input int k, input int len, input logic [7:0] addr,
                               input logic w, input logic [7:0] data);
        logic [7:0] e_bus;
        logic e_oe, e_cs, e_rd, e_wr, e_ad, e_done, e_val;
        int p;
        e_bus = 8'h00; e_oe = 1'b0; e_cs = 1'b1; e_rd = 1'b1; e_wr = 1'b1;
        e_ad = 1'b1; e_done = 1'b0; e_val = 1'b0;
        if (k >= 1 && k <= len) begin
            p = (k - 1) / TF;
            e_cs = 1'b0;
            if (p < 3) begin
                e_oe = 1'b1; e_bus = addr; e_wr = (p != 1);
            end else begin
                e_ad = 1'b0;
                if (w) begin
                    e_oe = 1'b1; e_bus = data; e_wr = (p != 4);
                end else begin
                    e_rd = (p != 4);
                end
            end
        end else if (k >= 1 && k == len + 1) begin
            e_done = 1'b1;
            e_val = !w && (addr < CMDB);
        end
        chk8($sformatf("bus@k%0d", k), out_bus, e_bus);
        chk1($sformatf("oe@k%0d", k), out_bus_oe, e_oe);
        chk1($sformatf("cs_n@k%0d", k), out_cs_n, e_cs);
        chk1($sformatf("rd_n@k%0d", k), out_rd_n, e_rd);
        chk1($sformatf("wr_n@k%0d", k), out_wr_n, e_wr);
        chk1($sformatf("ad@k%0d", k), out_ad, e_ad);
        chk1($sformatf("done@k%0d", k), out_flag_done, e_done);
        chk1($sformatf("valido@k%0d", k), out_dato_valido, e_val);
        chk8($sformatf("dato_leido@k%0d", k), out_dato_leido, exp_leido);
        chk8($sformatf("addr_leido@k%0d", k), out_addr_leido, exp_addr_leido);
        chk1($sformatf("no_drive_while_rd@k%0d", k), out_bus_oe & ~out_rd_n, 1'b0);
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle; returns at the negedge of the done
    // cycle (or right after asserting reset when abort_at matches).
    task automatic run_txn(input logic [7:0] addr, input logic w, input logic flag,
                           input logic [7:0] di, input logic [7:0] du,
                           input bit scramble, input bit hold_en,
                           input bit fixed_bus, input logic [7:0] bus_val,
                           input int abort_at, output int latency, output int done_cyc);
        int len;
        int start_cyc;
        logic [7:0] data;
        logic is_rd;
        data  = flag ? di : du;
        len   = (addr >= CMDB) ? 3 * TF : 6 * TF;
        is_rd = !w && (addr < CMDB);
        in_en_funcion_rtc = 1'b1;
        in_addr_ram_rtc = addr;
        in_funcion_w_r = w;
        in_flag_inicio = flag;
        in_dato_inicio = di;
        in_dato_usuario = du;
        in_bus = fixed_bus ? bus_val : 8'($urandom);
        start_cyc = cyc;
        latency = -1;
        done_cyc = -1;
        for (int k = 1; k <= len + 1; k++) begin
            @(negedge clk);
            if (k == len + 1) begin
                latency = cyc - start_cyc - 1;
                done_cyc = cyc;
                if (is_rd && exp_q.size() != 0) begin
                    exp_leido = exp_q.pop_front();
                    exp_addr_leido = addr;
                end
            end
            check_cycle(k, len, addr, w, data);
            if (k == abort_at) begin
                reset = 1'b1;
                return;
            end
            if (scramble) begin
                in_addr_ram_rtc = 8'($urandom);
                in_funcion_w_r = 1'($urandom_range(0, 1));
                in_flag_inicio = 1'($urandom_range(0, 1));
                in_dato_inicio = 8'($urandom);
                in_dato_usuario = 8'($urandom);
            end
            if (!hold_en) in_en_funcion_rtc = 1'($urandom_range(0, 1));
            in_bus = fixed_bus ? bus_val : 8'($urandom);
            if (is_rd && k == 5 * TF) exp_q.push_back(in_bus);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check_cycle(0, 0, 8'h00, 1'b0, 8'h00);
        in_en_funcion_rtc = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int lat, t1, t2;
        logic [7:0] a;

        reset = 1'b1;
        in_en_funcion_rtc = 1'b0;
        in_funcion_w_r = 1'b0;
        in_flag_inicio = 1'b0;
        in_addr_ram_rtc = 8'h00;
        in_dato_inicio = 8'h00;
        in_dato_usuario = 8'h00;
        in_bus = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cycle(0, 0, 8'h00, 1'b0, 8'h00);
        chk8("reset_state", 8'(dut.state_q), 8'(IDLE));
        reset = 1'b0;
        idle_cycle();

        // Write of init data to 8'h21
        run_txn(ADDR_SEG, 1'b1, 1'b1, 8'h00, 8'hA5, 1, 0, 0, 8'h00, 0, lat, t1);
        chk8("latency_full", 8'(lat), 8'd24);
        idle_cycle();

        // Read of 8'h43 returning 8'h59
        run_txn(ADDR_T_HORA, 1'b0, 1'b0, 8'h12, 8'h34, 1, 0, 1, 8'h59, 0, lat, t1);
        chk8("read_dato", out_dato_leido, 8'h59);
        chk8("read_addr", out_addr_leido, 8'h43);
        idle_cycle();
        chk8("read_dato_held", out_dato_leido, 8'h59);

        // Command cycles: write F1, read F2
        run_txn(ADDR_CMD_F1, 1'b1, 1'b1, 8'h77, 8'h66, 1, 0, 0, 8'h00, 0, lat, t1);
        chk8("latency_cmd", 8'(lat), 8'd12);
        idle_cycle();
        run_txn(ADDR_CMD_F2, 1'b0, 1'b0, 8'h77, 8'h66, 1, 0, 0, 8'h00, 0, lat, t1);
        chk8("latency_cmd_rd", 8'(lat), 8'd12);
        idle_cycle();

        // Back-to-back with request held high: 8'h41 then 8'h42
        run_txn(ADDR_T_SEG, 1'b1, 1'b1, 8'h11, 8'h22, 0, 1, 0, 8'h00, 0, lat, t1);
        @(negedge clk);
        check_cycle(0, 0, 8'h00, 1'b0, 8'h00);
        run_txn(ADDR_T_MIN, 1'b1, 1'b1, 8'h33, 8'h44, 0, 1, 0, 8'h00, 0, lat, t2);
        chk8("b2b_spacing", 8'(t2 - t1), 8'd26);
        idle_cycle();
        idle_cycle();

        // Reset in the middle of D_STROBE of a write
        run_txn(ADDR_HORA, 1'b1, 1'b1, 8'hC3, 8'h3C, 1, 0, 0, 8'h00, 4 * TF + 2, lat, t1);
        exp_leido = 8'h00;
        exp_addr_leido = 8'h00;
        exp_q.delete();
        @(negedge clk);
        check_cycle(0, 0, 8'h00, 1'b0, 8'h00);
        chk8("abort_state", 8'(dut.state_q), 8'(IDLE));
        reset = 1'b0;
        in_en_funcion_rtc = 1'b0;
        repeat (3) idle_cycle();
        run_txn(ADDR_DIA, 1'b1, 1'b0, 8'h00, 8'h5A, 1, 0, 0, 8'h00, 0, lat, t1);
        chk8("latency_after_abort", 8'(lat), 8'd24);
        idle_cycle();

        // User data select, user data scrambled after the latch
        run_txn(ADDR_MIN, 1'b1, 1'b0, 8'hFF, 8'h37, 1, 0, 0, 8'h00, 0, lat, t1);
        idle_cycle();

        // Randomized transactions
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) a = CMDB + 8'($urandom_range(0, 15));
            else a = 8'($urandom_range(0, 8'hEF));
            run_txn(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom), 8'($urandom), 1, 0, 0, 8'h00, 0, lat, t1);
            chk8("latency_rand", 8'(lat), (a >= CMDB) ? 8'(3 * TF) : 8'(6 * TF));
            idle_cycle();
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        chk8("exp_q_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
